// File: rtl/if_pc_fetch.sv
// if_pc_fetch
//   Instruction-fetch front end of the five-stage MIPS pipeline. Holds the
//   program counter, drives the instruction-memory address, and loads the
//   IF/ID pipeline register with the fetched word and PC+4. A taken
//   branch/jump resolved in MEM redirects the PC and squashes the wrong-path
//   instruction sitting in IF/ID.
//
// Parameters
//   RESET_PC     PC value loaded on reset
//   NOP_INSTR    bubble instruction written into IF/ID (sll $0,$0,0)
//
// Ports
//   clk                in   rising-edge clock
//   rst                in   synchronous reset, active-high
//   stall              in   hazard-unit hold (PC, IF/ID, fetch_cnt frozen)
//   mem_pcsrc          in   MEM-stage branch/jump taken
//   mem_branch_target  in   [31:0] redirect target from the MEM adder
//   imem_rdata         in   [31:0] instruction word at imem_addr (comb read)
//   imem_addr          out  [31:0] current PC
//   ifid_instr         out  [31:0] IF/ID instruction
//   ifid_npc           out  [31:0] IF/ID PC+4
//   ifid_valid         out  IF/ID holds a real (non-bubble) instruction
//   flush_out          out  squash request for ID/EX and EX/MEM this edge
//   misalign_err       out  sticky: a taken target had nonzero bits [1:0]
//   fetch_cnt          out  [31:0] valid instructions latched into IF/ID

module if_pc_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        mem_pcsrc,
  input  logic [31:0] mem_branch_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid,
  output logic        flush_out,
  output logic        misalign_err,
  output logic [31:0] fetch_cnt
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;
  logic        target_misaligned;

  // Wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
  assign pc_plus4          = pc + 32'd4;
  // Low two bits are dropped so the PC is always word-aligned; a nonzero
  // pair is reported through the sticky misalign_err instead of faulting.
  assign redirect_pc       = {mem_branch_target[31:2], 2'b00};
  assign target_misaligned = |mem_branch_target[1:0];

  assign imem_addr = pc;
  // Reset dominates a redirect, so no squash is requested during reset.
  assign flush_out = mem_pcsrc & ~rst;

  // Priority: reset > redirect (overrides stall) > stall > normal fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      ifid_instr   <= NOP_INSTR;
      ifid_npc     <= '0;
      ifid_valid   <= 1'b0;
      misalign_err <= 1'b0;
      fetch_cnt    <= '0;
    end else if (mem_pcsrc) begin
      pc         <= redirect_pc;
      ifid_instr <= NOP_INSTR;
      ifid_npc   <= '0;
      ifid_valid <= 1'b0;
      if (target_misaligned) begin
        misalign_err <= 1'b1;
      end
    end else if (!stall) begin
      pc         <= pc_plus4;
      ifid_instr <= imem_rdata;
      ifid_npc   <= pc_plus4;
      ifid_valid <= 1'b1;
      fetch_cnt  <= fetch_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_pc_fetch.sv
module tb_if_pc_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        mem_pcsrc;
  logic [31:0] mem_branch_target;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;
  logic        flush_out;
  logic        misalign_err;
  logic [31:0] fetch_cnt;

  always #5 clk = ~clk;

  if_pc_fetch #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .mem_pcsrc        (mem_pcsrc),
    .mem_branch_target(mem_branch_target),
    .imem_rdata       (imem_rdata),
    .imem_addr        (imem_addr),
    .ifid_instr       (ifid_instr),
    .ifid_npc         (ifid_npc),
    .ifid_valid       (ifid_valid),
    .flush_out        (flush_out),
    .misalign_err     (misalign_err),
    .fetch_cnt        (fetch_cnt)
  );

  // Instruction memory contents: word at address a is 0x2000_0000 + a.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2000_0000 + a;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural reference state.
  logic [31:0] m_pc    = RESET_PC;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_npc   = '0;
  logic        m_valid = 1'b0;
  logic        m_mis   = 1'b0;
  logic [31:0] m_cnt   = '0;

  task automatic check_state();
    check("imem_addr",    imem_addr,            m_pc);
    check("ifid_instr",   ifid_instr,           m_instr);
    check("ifid_npc",     ifid_npc,             m_npc);
    check("ifid_valid",   {31'b0, ifid_valid},  {31'b0, m_valid});
    check("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
    check("fetch_cnt",    fetch_cnt,            m_cnt);
  endtask

  // One clock cycle: apply inputs, check combinational outputs, clock,
  // advance the reference, check registered outputs.
  task automatic step(input logic r, input logic s, input logic p, input logic [31:0] t);
    rst = r; stall = s; mem_pcsrc = p; mem_branch_target = t;
    #1;
    check("flush_out", {31'b0, flush_out}, {31'b0, p & ~r});
    check("imem_addr_pre", imem_addr, m_pc);
    @(posedge clk);
    if (r) begin
      m_pc = RESET_PC; m_instr = NOP; m_npc = '0; m_valid = 1'b0; m_mis = 1'b0; m_cnt = '0;
    end else if (p) begin
      m_pc = t & 32'hFFFF_FFFC; m_instr = NOP; m_npc = '0; m_valid = 1'b0;
      if (t % 4 != 0) m_mis = 1'b1;
    end else if (!s) begin
      m_instr = mem_word(m_pc);
      m_npc   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_cnt   = m_cnt + 32'd1;
    end
    #1;
    check_state();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; mem_pcsrc = 1'b0; mem_branch_target = '0;
    @(posedge clk);
    #1;
    check_state();

    // Reset then free-running fetch from 0.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("seq_instr0", ifid_instr, 32'h2000_0000);
    check("seq_npc0",   ifid_npc,   32'd4);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("seq_instr2", ifid_instr, 32'h2000_0008);
    check("seq_npc2",   ifid_npc,   32'd12);
    check("seq_cnt",    fetch_cnt,  32'd3);

    // Taken branch from 0x40 to 0x100.
    step(0, 0, 1, 32'h40);
    step(0, 0, 1, 32'h100);
    check("br_pc",    imem_addr,          32'h100);
    check("br_valid", {31'b0, ifid_valid}, 32'd0);
    check("br_instr", ifid_instr,         NOP);
    step(0, 0, 0, 0);
    check("br_tgt_instr", ifid_instr, 32'h2000_0100);
    check("br_tgt_npc",   ifid_npc,   32'h104);

    // Three-cycle stall at 0x20.
    step(0, 0, 1, 32'h20);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    check("stall_pc", imem_addr, 32'h20);
    step(0, 0, 0, 0);
    check("stall_rel_instr", ifid_instr, 32'h2000_0020);
    check("stall_rel_npc",   ifid_npc,   32'h24);

    // Redirect together with stall.
    step(0, 1, 1, 32'h80);
    check("rs_pc",    imem_addr,          32'h80);
    check("rs_valid", {31'b0, ifid_valid}, 32'd0);

    // Misaligned target, sticky until reset.
    step(0, 0, 1, 32'h103);
    check("mis_pc",  imem_addr,            32'h100);
    check("mis_err", {31'b0, misalign_err}, 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    check("mis_sticky", {31'b0, misalign_err}, 32'd1);
    step(1, 0, 0, 0);
    check("mis_clear", {31'b0, misalign_err}, 32'd0);

    // PC wrap at the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    check("wrap_pc",    imem_addr, 32'h0);
    check("wrap_npc",   ifid_npc,  32'h0);
    check("wrap_instr", ifid_instr, 32'h1FFF_FFFC);

    // Reset together with redirect.
    step(0, 0, 0, 0);
    step(1, 0, 1, 32'h55);
    check("rstbr_pc",  imem_addr, RESET_PC);
    check("rstbr_cnt", fetch_cnt, 32'd0);

    // Randomized traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      logic        r, s, p;
      logic [31:0] t;
      r = ($urandom_range(49) == 0);
      s = ($urandom_range(3) == 0);
      p = ($urandom_range(7) == 0);
      t = $urandom;
      if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      step(r, s, p, t);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
